// File: rtl/vga_axis_timer_pkg.sv
// Shared VGA timing constants: 640x480 default segment lengths and the
// cfg_addr field encodings used by every axis timer instance.
package vga_axis_timer_pkg;

    typedef enum logic [1:0] {
        CFG_VIS  = 2'd0,
        CFG_FP   = 2'd1,
        CFG_SYNC = 2'd2,
        CFG_BP   = 2'd3
    } cfg_field_e;

    // Slots of the precomputed boundary register set
    localparam int BND_VIS_LAST   = 0;
    localparam int BND_SYNC_FIRST = 1;
    localparam int BND_SYNC_LAST  = 2;
    localparam int BND_TOTAL_LAST = 3;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

endpackage

// File: rtl/vga_axis_cfg.sv
// Pending/applied/boundary configuration registers for one timing axis, with
// write validation and the apply-time overflow check.
module vga_axis_cfg
    import vga_axis_timer_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DEF_VIS  = H_VIS,
    parameter int DEF_FP   = H_FP,
    parameter int DEF_SYNC = H_SYNC,
    parameter int DEF_BP   = H_BP
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_wr_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_data_i,
    input  logic             apply_i,
    output logic [WIDTH-1:0] vis_last_o,
    output logic [WIDTH-1:0] sync_first_o,
    output logic [WIDTH-1:0] sync_last_o,
    output logic [WIDTH-1:0] total_last_o,
    output logic             cfg_pending_o,
    output logic             cfg_err_o
);

    typedef logic [3:0][WIDTH-1:0] cfg_set_t;

    localparam cfg_set_t DEF_CFG = {WIDTH'(DEF_BP), WIDTH'(DEF_SYNC),
                                    WIDTH'(DEF_FP), WIDTH'(DEF_VIS)};
    localparam logic [WIDTH+1:0] ONE       = 1;
    localparam logic [WIDTH+1:0] MAX_TOTAL = {2'b01, {WIDTH{1'b0}}};

    cfg_set_t pend_q, pend_d;
    cfg_set_t app_q, app_d;
    cfg_set_t bnd_q, bnd_d;
    logic     err_q, err_d;

    logic [WIDTH+1:0] pend_sum;
    logic             apply_ok;
    logic             wr_reject;

    // Sums are formed two bits wider so an oversized mode cannot wrap silently.
    function automatic cfg_set_t calc_bounds(input cfg_set_t c);
        logic [WIDTH+1:0] v, f, s, b;
        cfg_set_t         r;
        v = {2'b00, c[CFG_VIS]};
        f = {2'b00, c[CFG_FP]};
        s = {2'b00, c[CFG_SYNC]};
        b = {2'b00, c[CFG_BP]};
        r[BND_VIS_LAST]   = WIDTH'(v - ONE);
        r[BND_SYNC_FIRST] = WIDTH'(v + f);
        r[BND_SYNC_LAST]  = WIDTH'(v + f + s - ONE);
        r[BND_TOTAL_LAST] = WIDTH'(v + f + s + b - ONE);
        return r;
    endfunction

    assign pend_sum = {2'b00, pend_q[CFG_VIS]} + {2'b00, pend_q[CFG_FP]}
                    + {2'b00, pend_q[CFG_SYNC]} + {2'b00, pend_q[CFG_BP]};
    assign apply_ok = (pend_sum <= MAX_TOTAL);

    assign wr_reject = cfg_wr_i && (cfg_data_i == '0)
                    && (cfg_addr_i == CFG_VIS || cfg_addr_i == CFG_SYNC);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        pend_d = pend_q;
        app_d  = app_q;
        bnd_d  = bnd_q;
        err_d  = err_q;

        // Apply reads pend_q, so a write on the same edge waits for the next wrap.
        if (apply_i) begin
            if (apply_ok) begin
                app_d = pend_q;
                bnd_d = calc_bounds(pend_q);
            end else begin
                err_d = 1'b1;
            end
        end

        if (cfg_wr_i) begin
            if (wr_reject) err_d = 1'b1;
            else           pend_d[cfg_addr_i] = cfg_data_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nrst) begin
            pend_q <= DEF_CFG;
            app_q  <= DEF_CFG;
            bnd_q  <= calc_bounds(DEF_CFG);
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            app_q  <= app_d;
            bnd_q  <= bnd_d;
            err_q  <= err_d;
        end
    end

    assign vis_last_o    = bnd_q[BND_VIS_LAST];
    assign sync_first_o  = bnd_q[BND_SYNC_FIRST];
    assign sync_last_o   = bnd_q[BND_SYNC_LAST];
    assign total_last_o  = bnd_q[BND_TOTAL_LAST];
    assign cfg_pending_o = (pend_q != app_q);
    assign cfg_err_o     = err_q;

endmodule

// File: rtl/vga_axis_timer.sv
// Single-axis VGA timing counter: position counter plus combinational decode
// of active video, sync and boundary strobes against the applied mode.
module vga_axis_timer
    import vga_axis_timer_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DEF_VIS  = H_VIS,
    parameter int DEF_FP   = H_FP,
    parameter int DEF_SYNC = H_SYNC,
    parameter int DEF_BP   = H_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             advance,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             sync_out,
    output logic             cnt_zero,
    output logic             vis_end,
    output logic             sync_begin,
    output logic             sync_end,
    output logic             cnt_end,
    output logic             wrap,
    output logic             cfg_pending,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] vis_last, sync_first, sync_last, total_last;
    logic             in_sync;

    vga_axis_cfg #(
        .WIDTH    (WIDTH),
        .DEF_VIS  (DEF_VIS),
        .DEF_FP   (DEF_FP),
        .DEF_SYNC (DEF_SYNC),
        .DEF_BP   (DEF_BP)
    ) u_cfg (
        .clk           (clk),
        .nrst          (nrst),
        .cfg_wr_i      (cfg_wr),
        .cfg_addr_i    (cfg_addr),
        .cfg_data_i    (cfg_data),
        .apply_i       (wrap),
        .vis_last_o    (vis_last),
        .sync_first_o  (sync_first),
        .sync_last_o   (sync_last),
        .total_last_o  (total_last),
        .cfg_pending_o (cfg_pending),
        .cfg_err_o     (cfg_err)
    );

    always_comb begin
        count_d = count_q;
        if (advance) count_d = cnt_end ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count      = count_q;
    assign cnt_zero   = (count_q == '0);
    assign vis_end    = (count_q == vis_last);
    assign sync_begin = (count_q == sync_first);
    assign sync_end   = (count_q == sync_last);
    assign cnt_end    = (count_q == total_last);
    assign wrap       = advance & cnt_end;
    assign active     = (count_q <= vis_last);

    // Sync window is inclusive of both precomputed endpoints.
    assign in_sync    = (count_q >= sync_first) && (count_q <= sync_last);
    assign sync_out   = in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_axis_timer.sv
// Scoreboard bench: horizontal and chained vertical axis timers; expected per-line
// timing records are queued up front and checked by a monitor at every line end.
module tb_vga_axis_timer;
    import vga_axis_timer_pkg::*;

    typedef struct {
        int   ve, sb, se, ce, act_n, sync_n;
        logic pend, err;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        h_adv;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        v_cfg_wr = 1'b0;
    logic [1:0]  v_cfg_addr = 2'd0;
    logic [11:0] v_cfg_data = 12'd0;

    logic [11:0] h_count, v_count;
    logic h_active, h_sync_out, h_cnt_zero, h_vis_end, h_sync_begin, h_sync_end;
    logic h_cnt_end, h_wrap, h_pend, h_err;
    logic v_active, v_sync_out, v_cnt_zero, v_vis_end, v_sync_begin, v_sync_end;
    logic v_cnt_end, v_wrap, v_pend, v_err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vga_axis_timer #(.WIDTH(12)) u_h (
        .clk(clk), .nrst(nrst), .advance(h_adv),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .count(h_count), .active(h_active), .sync_out(h_sync_out),
        .cnt_zero(h_cnt_zero), .vis_end(h_vis_end), .sync_begin(h_sync_begin),
        .sync_end(h_sync_end), .cnt_end(h_cnt_end), .wrap(h_wrap),
        .cfg_pending(h_pend), .cfg_err(h_err)
    );

    vga_axis_timer #(.WIDTH(12), .DEF_VIS(V_VIS), .DEF_FP(V_FP),
                     .DEF_SYNC(V_SYNC), .DEF_BP(V_BP)) u_v (
        .clk(clk), .nrst(nrst), .advance(h_wrap),
        .cfg_wr(v_cfg_wr), .cfg_addr(v_cfg_addr), .cfg_data(v_cfg_data),
        .count(v_count), .active(v_active), .sync_out(v_sync_out),
        .cnt_zero(v_cnt_zero), .vis_end(v_vis_end), .sync_begin(v_sync_begin),
        .sync_end(v_sync_end), .cnt_end(v_cnt_end), .wrap(v_wrap),
        .cfg_pending(v_pend), .cfg_err(v_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hand-computed line records: {vis_end, sync_begin, sync_end, cnt_end, active cycles, sync cycles}
    function automatic exp_t rec(input int ve, sb, se, ce, act_n, sync_n,
                                 input logic pend, err);
        exp_t e;
        e.ve = ve; e.sb = sb; e.se = se; e.ce = ce;
        e.act_n = act_n; e.sync_n = sync_n; e.pend = pend; e.err = err;
        return e;
    endfunction

    // Monitor: measures each full line while advance is high, compares at cnt_end.
    logic in_p = 1'b0;
    int   m_ve, m_sb, m_se, m_sf, m_act, m_sync;
    exp_t e;

    initial forever begin
        @(negedge clk);
        if (!nrst) begin
            in_p = 1'b0;
        end else if (h_adv) begin
            if (h_cnt_zero) begin
                in_p = 1'b1;
                m_ve = -1; m_sb = -1; m_se = -1; m_sf = -1; m_act = 0; m_sync = 0;
            end
            if (in_p) begin
                if (h_active) m_act++;
                if (h_sync_out == 1'b0) begin
                    if (m_sync == 0) m_sf = int'(h_count);
                    m_sync++;
                end
                if (h_vis_end)    m_ve = int'(h_count);
                if (h_sync_begin) m_sb = int'(h_count);
                if (h_sync_end)   m_se = int'(h_count);
                if (h_cnt_end) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_line: line ended at %0d, no record queued", h_count);
                    end else begin
                        e = exp_q.pop_front();
                        check("vis_end_pos",    m_ve, e.ve);
                        check("sync_begin_pos", m_sb, e.sb);
                        check("sync_low_first", m_sf, e.sb);
                        check("sync_end_pos",   m_se, e.se);
                        check("cnt_end_pos",    int'(h_count), e.ce);
                        check("active_cycles",  m_act, e.act_n);
                        check("sync_cycles",    m_sync, e.sync_n);
                        check("wrap_at_end",    int'(h_wrap), 1);
                        check("pending_at_end", int'(h_pend), int'(e.pend));
                        check("err_at_end",     int'(h_err), int'(e.err));
                    end
                    in_p = 1'b0;
                end
            end
        end
    end

    task automatic wait_count(input int target);
        int n = 0;
        @(negedge clk);
        while (int'(h_count) != target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_count", int'(h_count), target);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [11:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_h_count",  int'(h_count), 0);
        check("rst_v_count",  int'(v_count), 0);
        check("rst_cnt_zero", int'(h_cnt_zero), 1);
        check("rst_active",   int'(h_active), 1);
        check("rst_sync_out", int'(h_sync_out), 1);
        check("rst_wrap",     int'(h_wrap), 0);
        check("rst_pending",  int'(h_pend), 0);
        check("rst_err",      int'(h_err), 0);
    endtask

    initial begin
        nrst = 1'b0; h_adv = 1'b1; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 12'd0;

        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b0, 1'b0)); // L1 defaults
        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b1, 1'b0)); // L2 VIS=800 pending
        exp_q.push_back(rec(799, 816, 911, 959, 800, 96, 1'b1, 1'b0)); // L3 VIS=800 applied
        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b1, 1'b0)); // L4 oversize pending
        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b0, 1'b1)); // L5 rejected apply
        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b1, 1'b1)); // L6 FP=0 pending
        exp_q.push_back(rec(639, 640, 735, 783, 640, 96, 1'b0, 1'b1)); // L7 FP=0 applied
        exp_q.push_back(rec(639, 640, 735, 783, 640, 96, 1'b0, 1'b1)); // L8 with advance stall

        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        nrst = 1'b1;

        wait_count(50);
        check("l1_pending", int'(h_pend), 0);
        check("l1_v_count", int'(v_count), 0);
        wait_count(799);

        wait_count(100);
        cfg_write(CFG_VIS, 12'd800);
        check("vis800_pending", int'(h_pend), 1);
        wait_count(799);

        wait_count(10);
        check("after_apply_pending", int'(h_pend), 0);
        wait_count(100);
        cfg_write(CFG_VIS, 12'd640);
        wait_count(959);

        wait_count(100);
        cfg_write(CFG_VIS, 12'd4000);
        cfg_write(CFG_BP, 12'd200);
        wait_count(799);

        wait_count(5);
        check("overflow_err", int'(h_err), 1);
        check("overflow_pending_kept", int'(h_pend), 1);
        wait_count(100);
        cfg_write(CFG_VIS, 12'd640);
        cfg_write(CFG_BP, 12'd48);
        cfg_write(CFG_VIS, 12'd0);
        cfg_write(CFG_SYNC, 12'd0);
        check("zero_write_pending", int'(h_pend), 0);
        check("zero_write_err", int'(h_err), 1);
        wait_count(799);
        cfg_write(CFG_FP, 12'd0);        // lands on the wrap edge itself

        wait_count(100);
        check("fp0_pending", int'(h_pend), 1);
        wait_count(799);
        wait_count(783);

        wait_count(783);
        h_adv = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stall_count", int'(h_count), 783);
            check("stall_wrap", int'(h_wrap), 0);
            check("stall_cnt_end", int'(h_cnt_end), 1);
        end
        #1 h_adv = 1'b1;

        wait_count(5);
        check("v_count_after_8", int'(v_count), 8);

        wait_count(300);
        cfg_write(CFG_VIS, 12'd700);
        nrst = 1'b0;
        exp_q.push_back(rec(639, 656, 751, 799, 640, 96, 1'b0, 1'b0)); // line after reset
        @(posedge clk); @(posedge clk); #1;
        check_reset_state();
        nrst = 1'b1;

        wait_count(799);
        wait_count(3);
        check("v_count_after_reset", int'(v_count), 1);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_axis_timer.md
# vga_axis_timer

Parametrised single-axis VGA timing counter; one instance generates horizontal timing and a second, advanced by the first one's wrap, generates vertical timing. Counts 0..TOTAL-1, where TOTAL = VIS+FP+SYNC+BP. Decodes the boundary strobes, the active-video flag and the sync output. Segment lengths are runtime-programmable through shadow registers that take effect only at a frame/line boundary, so a mode change never produces a truncated or torn period.

## Interface
- WIDTH, 12: counter and config field width.
- DEF_VIS, 640: reset visible length.
- DEF_FP, 16: reset front-porch length.
- DEF_SYNC, 96: reset sync length.
- DEF_BP, 48: reset back-porch length.
- SYNC_POL, 0: sync level while asserted (0 = active-low output).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- advance  in  1  count enable; the counter updates only on cycles where advance=1.
- cfg_wr  in  1  write strobe for a pending config field.
- cfg_addr  in  2  field select: 0 VIS, 1 FP, 2 SYNC, 3 BP.
- cfg_data  in  WIDTH  field value.
- count  out  WIDTH  current position.
- active  out  1  high while count < VIS.
- sync_out  out  1  equals SYNC_POL while count is in [VIS+FP, VIS+FP+SYNC), otherwise ~SYNC_POL.
- cnt_zero, vis_end, sync_begin, sync_end, cnt_end  out  1  boundary strobes: count==0, VIS-1, VIS+FP, VIS+FP+SYNC-1, TOTAL-1 respectively.
- wrap  out  1  advance & cnt_end; drives the next axis's advance.
- cfg_pending  out  1  pending config differs from the applied config.
- cfg_err  out  1  sticky; set by a rejected write or a rejected apply.

## Operation
- Three config register sets:
  - Pending: VIS/FP/SYNC/BP, written by cfg_wr.
  - Applied: the config in effect.
  - Boundary registers: vis_last, sync_first, sync_last, total_last, precomputed from the applied config.
- Writes:
  - Write of 0 to VIS or SYNC: ignored, cfg_err set.
  - FP=0 and BP=0 are legal.
- Count update:
  - advance & ~cnt_end: count <= count+1.
  - advance & cnt_end: count <= 0, and an apply attempt occurs on the same edge.
- Apply:
  - Width rule: sum the pending fields in WIDTH+2 bits.
  - If the sum is ≤ 2^WIDTH: copy pending to applied, and load the boundary registers with the values computed from pending.
  - Otherwise: keep the applied config, set cfg_err, and leave pending unchanged.
- Simultaneous cfg_wr and apply on the same edge: the apply uses the pre-write pending value; the new write lands in pending for the next wrap.
- All strobes, active and sync_out are combinational compares of count against the boundary registers.
  - FP=0: vis_end and the cycle before sync_begin coincide; no special case.
  - BP=0: sync_end and cnt_end are asserted together.
- advance=0: count, strobes and outputs hold; wrap=0.

## Timing
- Reset (nrst=0 at a clk edge):
  - count=0.
  - Pending and applied = DEF_*; boundary registers loaded from DEF_*.
  - cfg_err=0, cfg_pending=0.
  - Resulting outputs: cnt_zero=1, active=1, sync_out=~SYNC_POL, wrap=advance&0=0.
- Reset mid-period discards any pending changes immediately.
- Strobe latency: 0 cycles relative to count. A new config is visible starting from count=0 of the next period.
- cfg_pending updates 1 cycle after cfg_wr and clears on the edge of a successful apply.
- Single-field writes are independent. Multi-field changes must all land before the wrap to apply atomically; the block enforces no ordering.

## Structure
- Shared timing include/package: default mode constants (640x480 horizontal and vertical sets) and the cfg_addr field encodings.
- One sub-module: vga_axis_cfg, which owns the pending/applied/boundary registers, write validation and the overflow check, and exports the boundary values and the error flag.
- The top level owns the counter and the decode.

## Test plan
- Reset, then advance held high with defaults: wrap every 800 cycles; active for counts 0..639; sync_out low for counts 656..751; sync_begin at 656, sync_end at 751, cnt_end at 799.
- Write VIS=800 at count 100: cfg_pending=1; the current period still ends at 799. The next period has active for counts 0..799, cnt_end at 959, and cfg_pending=0 after the wrap.
- Write VIS=0 or SYNC=0: ignored; cfg_err=1 and stays set until reset. Timing is unchanged.
- WIDTH=12, write VIS=4000 and BP=200 (sum 4312 > 4096): at the wrap the applied config stays at the defaults and cfg_err=1.
- cfg_wr FP=0 on the exact wrap edge: the period following that wrap keeps FP=16, and the period after it uses FP=0, with sync_begin at 640.
- Two chained instances (vertical defaults 480/10/2/33), reset asserted mid-frame: both counters go to 0 and all config returns to defaults. Vertical count advances exactly once per horizontal wrap.
